// File: rtl/seg_scan_if.sv
// rtl/seg_scan_if.sv - load/display bundle between the scan controller and its host
interface seg_scan_if #(
  parameter int NUM_DIGITS = 8
);
  logic                          load;
  logic [4*NUM_DIGITS-1:0]       value;
  logic [NUM_DIGITS-1:0]         digit_en;
  logic                          pending;
  logic [3:0]                    digit;
  logic [$clog2(NUM_DIGITS)-1:0] digit_idx;
  logic [NUM_DIGITS-1:0]         anodes;
  logic                          frame_done;

  modport master (
    output load, value, digit_en,
    input  pending, digit, digit_idx, anodes, frame_done
  );

  modport slave (
    input  load, value, digit_en,
    output pending, digit, digit_idx, anodes, frame_done
  );
endinterface

// File: rtl/seg_scan_controller.sv
// rtl/seg_scan_controller.sv - 7-segment digit scanner with blanking gap and frame-aligned value commit
// Optional leading-zero suppression: define SEG_SCAN_LEADING_ZERO_BLANK_EN.
module seg_scan_controller #(
  parameter int DIVISOR      = 10000,
  parameter int BLANK_CYCLES = 50,
  parameter int NUM_DIGITS   = 8
) (
  input logic        clk_5MHz,
  input logic        reset,
  seg_scan_if.slave  bus
);
  localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         shadow_q, shadow_d;
  logic [VW-1:0]         active_q, active_d;
  logic                  pending_q, pending_d;
  logic [NUM_DIGITS-1:0] anodes_q, anodes_d;
  logic [3:0]            digit_q, digit_d;
  logic                  frame_done_q, frame_done_d;
  logic                  show;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  logic                  upper_zero;
`endif

  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // frame_done_q marks the last cycle of the frame, which is the commit cycle
    shadow_d  = shadow_q;
    pending_d = pending_q;
    active_d  = active_q;
    if (bus.load) begin
      shadow_d  = bus.value;
      pending_d = 1'b1;
    end
    if (frame_done_q) begin
      if (bus.load) begin
        active_d  = bus.value;
        pending_d = 1'b0;
      end else if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end

    state_d = state_q;
    case (state_q)
      ST_BLANK: if (cnt_d >= CNT_BLANK) state_d = ST_DRIVE;
      ST_DRIVE: if (cnt_d < CNT_BLANK)  state_d = ST_BLANK;
      default:  state_d = ST_BLANK;
    endcase

    show = bus.digit_en[idx_d];
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      upper_zero = upper_zero & (active_d[4*i +: 4] == 4'd0);
      if ((IW'(i) == idx_d) && upper_zero) show = 1'b0;
    end
`endif

    anodes_d = '1;
    if ((state_d == ST_DRIVE) && show) anodes_d[idx_d] = 1'b0;
    digit_d      = active_d[{idx_d, 2'b00} +: 4];
    frame_done_d = (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
  end

  always_ff @(posedge clk_5MHz) begin
    if (reset) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      anodes_q     <= '1;
      digit_q      <= 4'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      anodes_q     <= anodes_d;
      digit_q      <= digit_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.pending    = pending_q;
  assign bus.digit      = digit_q;
  assign bus.digit_idx  = idx_q;
  assign bus.anodes     = anodes_q;
  assign bus.frame_done = frame_done_q;
endmodule
